// File: rtl/midi_uart_pkg.sv
// Shared definitions for the MIDI UART: FSM state encoding, MIDI baud rate
// and a helper that derives the bit period from the clock frequency.
package midi_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int MIDI_BAUD = 31250;

  // Rounded to the nearest whole clock so the baud error stays minimal.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-cell prescaler: counts clk cycles while run is high and flags the
// last cycle of each CLKS_PER_BIT-long cell on tick.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || !run || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/midi_uart_tx.sv
// UART transmitter that pops words from a first-word-fall-through FIFO and
// serialises them (start, LSB-first data, optional parity, stop bits).
module midi_uart_tx
  import midi_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] data_i,
  input  logic              fifo_empty_n,
  output logic              fifo_rd,
  output logic              ser_o,
  output logic              busy,
  output logic              tx_done,
  output logic [2:0]        state_dbg
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  // Handshake: fifo_rd is a single-cycle pop strobe; data_i is valid whenever
  // fifo_empty_n is high and is captured on the clock edge that ends the
  // fifo_rd cycle, so the FIFO advances on that same edge.

  tx_state_e         state, state_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              parity_q, parity_n;
  logic              ser_n;
  logic              tick;
  logic              last_stop;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(fifo_rd),
    .run  (state != ST_IDLE),
    .tick (tick)
  );

  assign last_stop = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
  // Gated by reset so no pop can slip out while the block is held in reset.
  assign fifo_rd   = !reset && en && fifo_empty_n && ((state == ST_IDLE) || last_stop);
  assign busy      = (state != ST_IDLE);
  assign tx_done   = last_stop;
  assign state_dbg = state;
  assign parity_n  = fifo_rd ? ((^data_i) ^ ODD_BIT) : parity_q;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    unique case (state)
      ST_IDLE: begin
        if (fifo_rd) begin
          state_n   = ST_START;
          shift_n   = data_i;
          bit_cnt_n = '0;
        end
      end
      ST_START: begin
        if (tick) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_DATA) begin
            state_n   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            shift_n   = shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (last_stop) begin
          bit_cnt_n = '0;
          if (fifo_rd) begin
            state_n = ST_START;
            shift_n = data_i;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (tick) begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      default: begin
        state_n   = ST_IDLE;
        bit_cnt_n = '0;
      end
    endcase

    // ser_o is registered, so it is derived from the upcoming state.
    unique case (state_n)
      ST_START:  ser_n = 1'b0;
      ST_DATA:   ser_n = shift_n[0];
      ST_PARITY: ser_n = parity_q;
      default:   ser_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      parity_q <= 1'b0;
      ser_o    <= 1'b1;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      parity_q <= parity_n;
      ser_o    <= ser_n;
    end
  end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx: three instances cover 8N1, 8E2 and 5N1
// framing, each fed from a queue that behaves like a fall-through FIFO.
module tb_midi_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       en0, fe0;
  logic [7:0] d0;
  wire        rd0, ser0, busy0, done0;
  wire  [2:0] st0;

  logic       en1, fe1;
  logic [7:0] d1;
  wire        rd1, ser1, busy1, done1;
  wire  [2:0] st1;

  logic       en2, fe2;
  logic [4:0] d2;
  wire        rd2, ser2, busy2, done2;
  wire  [2:0] st2;

  midi_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .en(en0), .data_i(d0), .fifo_empty_n(fe0),
    .fifo_rd(rd0), .ser_o(ser0), .busy(busy0), .tx_done(done0), .state_dbg(st0));

  midi_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_par (
    .clk(clk), .reset(reset), .en(en1), .data_i(d1), .fifo_empty_n(fe1),
    .fifo_rd(rd1), .ser_o(ser1), .busy(busy1), .tx_done(done1), .state_dbg(st1));

  midi_uart_tx #(.CLKS_PER_BIT(3), .DATA_W(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_w5 (
    .clk(clk), .reset(reset), .en(en2), .data_i(d2), .fifo_empty_n(fe2),
    .fifo_rd(rd2), .ser_o(ser2), .busy(busy2), .tx_done(done2), .state_dbg(st2));

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [4:0] q2[$];
  logic [7:0] exp_q[$];

  logic [2:0] obs_rd, obs_ser, obs_busy, obs_done;
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock/reset and driver tasks ----------------
  task automatic refresh();
    fe0 = (q0.size() != 0);
    d0  = fe0 ? q0[0] : 8'h00;
    fe1 = (q1.size() != 0);
    d1  = fe1 ? q1[0] : 8'h00;
    fe2 = (q2.size() != 0);
    d2  = fe2 ? q2[0] : 5'h00;
  endtask

  // One clock cycle: sample mid-cycle, let the edge happen, pop popped words.
  task automatic cyc();
    #1;
    obs_rd   = {rd2, rd1, rd0};
    obs_ser  = {ser2, ser1, ser0};
    obs_busy = {busy2, busy1, busy0};
    obs_done = {done2, done1, done0};
    @(posedge clk);
    #1;
    if (obs_rd[0] && q0.size() != 0) q0.delete(0);
    if (obs_rd[1] && q1.size() != 0) q1.delete(0);
    if (obs_rd[2] && q2.size() != 0) q2.delete(0);
    refresh();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    refresh();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ser2, ser1, ser0} !== 3'b111) $display("FAIL reset_ser: got %b want 111", {ser2, ser1, ser0});
    else n_pass++;
    n_checks++;
    if ({busy2, busy1, busy0} !== 3'b000) $display("FAIL reset_busy: got %b want 000", {busy2, busy1, busy0});
    else n_pass++;
    n_checks++;
    if ({rd2, rd1, rd0} !== 3'b000) $display("FAIL reset_rd: got %b want 000", {rd2, rd1, rd0});
    else n_pass++;
    n_checks++;
    if ({done2, done1, done0} !== 3'b000) $display("FAIL reset_done: got %b want 000", {done2, done1, done0});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [9:0] cells;
    logic       exp_ser;
    int rd_cnt, busy_cnt, done_cnt, done_at;
    cells = 10'b11_0010_0000;  // 0x90: start, 0,0,0,0,1,0,0,1, stop
    rd_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    q0.push_back(8'h90);
    refresh();
    en0 = 1'b1;
    for (int k = 0; k <= 42; k++) begin
      cyc();
      if (k == 0) begin
        n_checks++;
        if (obs_rd[0] !== 1'b1) $display("FAIL single_first_pop: got %b want 1", obs_rd[0]);
        else n_pass++;
      end
      if (obs_rd[0]) rd_cnt++;
      if (obs_busy[0]) busy_cnt++;
      if (obs_done[0]) begin done_cnt++; done_at = k; end
      exp_ser = (k == 0 || k > 40) ? 1'b1 : cells[(k - 1) / 4];
      n_checks++;
      if (obs_ser[0] !== exp_ser) $display("FAIL single_ser cycle %0d: got %b want %b", k, obs_ser[0], exp_ser);
      else n_pass++;
    end
    en0 = 1'b0;
    n_checks++;
    if (rd_cnt != 1) $display("FAIL single_rd_count: got %0d want 1", rd_cnt);
    else n_pass++;
    n_checks++;
    if (busy_cnt != 40) $display("FAIL single_busy_cycles: got %0d want 40", busy_cnt);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || done_at != 40) $display("FAIL single_tx_done: got %0d pulses last at %0d want 1 at 40", done_cnt, done_at);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ser_log[0:123];
    logic busy_log[0:123];
    int   rd_cyc[$];
    int   done_cyc[$];
    int   base;
    logic [7:0] got, want;
    q0.push_back(8'h90); q0.push_back(8'h3C); q0.push_back(8'h7F);
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h7F);
    refresh();
    en0 = 1'b1;
    for (int k = 0; k <= 123; k++) begin
      cyc();
      ser_log[k]  = obs_ser[0];
      busy_log[k] = obs_busy[0];
      if (obs_rd[0]) rd_cyc.push_back(k);
      if (obs_done[0]) done_cyc.push_back(k);
    end
    en0 = 1'b0;
    n_checks++;
    if (rd_cyc.size() != 3 || rd_cyc[0] != 0 || rd_cyc[1] != 40 || rd_cyc[2] != 80)
      $display("FAIL b2b_rd_cycles: got %p want 0,40,80", rd_cyc);
    else n_pass++;
    n_checks++;
    if (done_cyc.size() != 3 || done_cyc[0] != 40 || done_cyc[1] != 80 || done_cyc[2] != 120)
      $display("FAIL b2b_done_cycles: got %p want 40,80,120", done_cyc);
    else n_pass++;
    n_checks++;
    if (busy_log[40] !== 1'b1 || busy_log[41] !== 1'b1 || ser_log[41] !== 1'b0)
      $display("FAIL b2b_no_gap: got busy %b%b ser %b want busy 11 ser 0", busy_log[40], busy_log[41], ser_log[41]);
    else n_pass++;
    n_checks++;
    if (busy_log[121] !== 1'b0) $display("FAIL b2b_idle_after: got %b want 0", busy_log[121]);
    else n_pass++;
    for (int f = 0; f < 3; f++) begin
      base = f * 40;
      for (int b = 0; b < 8; b++) got[b] = ser_log[base + 7 + 4 * b];
      want = exp_q.pop_front();
      n_checks++;
      if (ser_log[base + 3] !== 1'b0 || ser_log[base + 39] !== 1'b1 || got !== want)
        $display("FAIL b2b_frame%0d: got start %b data %h stop %b want 0 %h 1", f, ser_log[base + 3], got, ser_log[base + 39], want);
      else n_pass++;
    end
  endtask

  task automatic test_parity();
    logic [11:0] cells;
    logic        exp_ser;
    int rd_cnt, busy_cnt, done_cnt, done_at;
    cells = 12'hE0E;  // 0x07: start, 1,1,1,0,0,0,0,0, parity 1, stop, stop
    rd_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    q1.push_back(8'h07);
    refresh();
    en1 = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      cyc();
      if (obs_rd[1]) rd_cnt++;
      if (obs_busy[1]) busy_cnt++;
      if (obs_done[1]) begin done_cnt++; done_at = k; end
      exp_ser = (k == 0 || k > 48) ? 1'b1 : cells[(k - 1) / 4];
      n_checks++;
      if (obs_ser[1] !== exp_ser) $display("FAIL parity_ser cycle %0d: got %b want %b", k, obs_ser[1], exp_ser);
      else n_pass++;
    end
    en1 = 1'b0;
    n_checks++;
    if (rd_cnt != 1 || busy_cnt != 48) $display("FAIL parity_len: got rd %0d busy %0d want 1 48", rd_cnt, busy_cnt);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || done_at != 48) $display("FAIL parity_tx_done: got %0d pulses last at %0d want 1 at 48", done_cnt, done_at);
    else n_pass++;
  endtask

  task automatic test_width();
    logic [6:0] cells;
    logic       exp_ser;
    int busy_cnt, done_cnt, done_at;
    cells = 7'b110_1010;  // 0x15 in 5 bits: start, 1,0,1,0,1, stop
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    q2.push_back(5'h15);
    refresh();
    en2 = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      cyc();
      if (obs_busy[2]) busy_cnt++;
      if (obs_done[2]) begin done_cnt++; done_at = k; end
      exp_ser = (k == 0 || k > 21) ? 1'b1 : cells[(k - 1) / 3];
      n_checks++;
      if (obs_ser[2] !== exp_ser) $display("FAIL width5_ser cycle %0d: got %b want %b", k, obs_ser[2], exp_ser);
      else n_pass++;
    end
    en2 = 1'b0;
    n_checks++;
    if (busy_cnt != 21 || done_cnt != 1 || done_at != 21)
      $display("FAIL width5_len: got busy %0d done %0d at %0d want 21 1 21", busy_cnt, done_cnt, done_at);
    else n_pass++;
  endtask

  task automatic test_en_drop();
    int rd_cnt, done_cnt, done_at;
    rd_cnt = 0; done_cnt = 0; done_at = -1;
    q0.push_back(8'h11); q0.push_back(8'h22);
    refresh();
    en0 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 10) en0 = 1'b0;
      cyc();
      if (obs_rd[0]) rd_cnt++;
      if (obs_done[0]) begin done_cnt++; done_at = k; end
    end
    n_checks++;
    if (rd_cnt != 1 || q0.size() != 1) $display("FAIL en_drop_no_pop: got %0d pops, %0d queued want 1 1", rd_cnt, q0.size());
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || done_at != 40) $display("FAIL en_drop_finish: got %0d pulses at %0d want 1 at 40", done_cnt, done_at);
    else n_pass++;
    n_checks++;
    if (obs_busy[0] !== 1'b0) $display("FAIL en_drop_idle: got busy %b want 0", obs_busy[0]);
    else n_pass++;
    en0 = 1'b1;
    cyc();
    n_checks++;
    if (obs_rd[0] !== 1'b1) $display("FAIL en_rise_pop: got %b want 1", obs_rd[0]);
    else n_pass++;
    en0 = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 42; k++) begin
      cyc();
      if (obs_done[0]) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 1) $display("FAIL en_rise_frame: got %0d pulses want 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    q0.push_back(8'h55);
    refresh();
    en0 = 1'b1;
    repeat (15) cyc();
    q0.push_back(8'h33);
    refresh();
    reset = 1'b1;
    #1;
    n_checks++;
    if (ser0 !== 1'b1 || busy0 !== 1'b0 || st0 !== 3'd0)
      $display("FAIL reset_mid_async: got ser %b busy %b state %0d want 1 0 0", ser0, busy0, st0);
    else n_pass++;
    repeat (2) begin
      cyc();
      n_checks++;
      if (obs_rd[0] !== 1'b0) $display("FAIL reset_mid_no_pop: got %b want 0", obs_rd[0]);
      else n_pass++;
    end
    en0 = 1'b0;
    reset = 1'b0;
    cyc();
    n_checks++;
    if (obs_rd[0] !== 1'b0 || obs_ser[0] !== 1'b1) $display("FAIL reset_release_idle: got rd %b ser %b want 0 1", obs_rd[0], obs_ser[0]);
    else n_pass++;
    en0 = 1'b1;
    cyc();
    n_checks++;
    if (obs_rd[0] !== 1'b1) $display("FAIL reset_release_pop: got %b want 1", obs_rd[0]);
    else n_pass++;
    en0 = 1'b0;
    done_cnt = 0;
    repeat (42) begin
      cyc();
      if (obs_done[0]) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 1 || q0.size() != 0) $display("FAIL reset_release_frame: got %0d pulses, %0d queued want 1 0", done_cnt, q0.size());
    else n_pass++;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    refresh();
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_width();
    test_en_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
